dbus_ctrl: RTL and testbench

//  Data-bus controller between the rv32i_core data port and its slaves (RAM, UART).

---
 rtl/dbus_pkg.sv | 31 +++
 rtl/dbus_addr_dec.sv | 19 +
 rtl/dbus_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dbus_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared types for the data-bus controller: FSM states, slave and master ids,
// and the request bundle latched for UART accesses.
package dbus_pkg;

  localparam int MODE_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UART_CORE = 2'd1,
    UART_M1   = 2'd2
  } dbus_state_t;

  // Slave ids line up with the core's bus id encoding.
  typedef enum logic {
    RAM  = 1'b0,
    UART = 1'b1
  } slave_e;

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_M1   = 1'b1
  } master_e;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [MODE_W-1:0] mode;
  } dbus_req_t;

endpackage

// File: rtl/dbus_addr_dec.sv
// Region decoder: anything matching the UART base above DEC_LSB goes to the
// UART, everything else is RAM. Only the decoded upper address bits come in.
module dbus_addr_dec
  import dbus_pkg::*;
#(
  parameter logic [31:0] UART_BASE = 32'h8000_0000,
  parameter int          DEC_LSB   = 12
) (
  input  logic [31-DEC_LSB:0] region,
  output slave_e              sel
);

  // Compare the region bits against the UART base
  always_comb begin
    sel = RAM;
    if (region == UART_BASE[31:DEC_LSB]) sel = UART;
  end

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus controller: arbitrates the core against M1, forwards RAM accesses
// combinationally, runs UART accesses through a small FSM with an ack timeout,
// and routes read data back to whichever master issued it.
module dbus_ctrl
  import dbus_pkg::*;
#(
  parameter logic [31:0] UART_BASE  = 32'h8000_0000,
  parameter int          DEC_LSB    = 12,
  parameter int          STARVE_LIM = 4,
  parameter int          UART_TMO   = 255
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic              core_wrEn,
  input  logic              core_rdEn,
  input  logic [MODE_W-1:0] core_mode,
  output logic              core_clkEn,
  output logic [31:0]       core_rdata,
  output logic              core_rdataEn,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [MODE_W-1:0] m1_mode,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [MODE_W-1:0] ram_mode,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       uart_addr,
  output logic [31:0]       uart_wdata,
  output logic              uart_we,
  output logic              uart_re,
  input  logic [31:0]       uart_rdata,
  input  logic              uart_ack,
  output logic              bus_err
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIM + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);
  localparam logic [7:0]          TMO_MAX    = 8'(UART_TMO);

  dbus_state_t         state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [7:0]          tmo_q, tmo_d;
  logic                rd_pend_q, rd_pend_d;
  master_e             rd_owner_q, rd_owner_d;
  logic                bus_err_q, bus_err_d;
  dbus_req_t           lat_q, lat_d;

  dbus_req_t core_bus, m1_bus, win_req;
  slave_e    win_sel;
  logic      core_req, in_idle, in_uart;
  logic      m1_win, core_win, issue_ram, issue_uart;
  logic      uart_done, uart_tmo;

  assign core_bus = {core_wrEn, core_addr, core_wdata, core_mode};
  assign m1_bus   = {m1_we, m1_addr, m1_wdata, m1_mode};

  // Pick this cycle's bus owner; M1 only beats a requesting core once starved
  always_comb begin
    core_req = core_wrEn | core_rdEn;
    in_idle  = (state_q == IDLE);
    m1_win   = in_idle & m1_req & (~core_req | (starve_q == STARVE_MAX));
    core_win = in_idle & core_req & ~m1_win;
    win_req  = m1_win ? m1_bus : core_bus;
  end

  dbus_addr_dec #(
    .UART_BASE (UART_BASE),
    .DEC_LSB   (DEC_LSB)
  ) u_dec (
    .region (win_req.addr[31:DEC_LSB]),
    .sel    (win_sel)
  );

  assign issue_ram  = (m1_win | core_win) & (win_sel == RAM);
  assign issue_uart = (m1_win | core_win) & (win_sel == UART);
  assign in_uart    = ~in_idle;
  // An ack wins over a coincident timeout, so the error flag only sees a bare timeout.
  assign uart_tmo   = in_uart & ~uart_ack & (tmo_q == TMO_MAX);
  assign uart_done  = in_uart & (uart_ack | (tmo_q == TMO_MAX));
  assign bus_err    = bus_err_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstB) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      tmo_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= MST_CORE;
      bus_err_q  <= 1'b0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      bus_err_q  <= bus_err_d;
      lat_q      <= lat_d;
    end
  end

  // Next state: UART issues leave IDLE, ack or timeout returns to it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:              if (issue_uart) state_d = m1_win ? UART_M1 : UART_CORE;
      UART_CORE, UART_M1: if (uart_done) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Next values for starvation, timeout, read-tag, error and latched request
  always_comb begin
    if (!m1_req || m1_win || state_q == UART_M1) starve_d = '0;
    else if (starve_q != STARVE_MAX)            starve_d = starve_q + 1'b1;
    else                                         starve_d = starve_q;

    tmo_d      = (in_uart && !uart_done) ? tmo_q + 8'd1 : 8'd0;
    rd_pend_d  = issue_ram & ~win_req.we;
    rd_owner_d = m1_win ? MST_M1 : MST_CORE;
    bus_err_d  = bus_err_q | uart_tmo;
    lat_d      = issue_uart ? win_req : lat_q;
  end

  // Outputs: RAM forwarding, UART strobes, stalls, grants and read returns
  always_comb begin
    core_clkEn   = 1'b1;
    core_rdata   = '0;
    core_rdataEn = 1'b0;
    m1_gnt       = 1'b0;
    m1_rvalid    = 1'b0;
    m1_rdata     = '0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_mode     = '0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    uart_addr    = '0;
    uart_wdata   = '0;
    uart_we      = 1'b0;
    uart_re      = 1'b0;

    if (issue_ram) begin
      ram_addr  = win_req.addr;
      ram_wdata = win_req.wdata;
      ram_mode  = win_req.mode;
      ram_we    = win_req.we;
      ram_re    = ~win_req.we;
      if (m1_win) m1_gnt = 1'b1;
    end
    if (m1_win && core_req)     core_clkEn = 1'b0;
    if (core_win && issue_uart) core_clkEn = 1'b0;

    if (in_uart) begin
      uart_addr  = lat_q.addr;
      uart_wdata = lat_q.wdata;
      uart_we    = lat_q.we;
      uart_re    = ~lat_q.we;
    end

    case (state_q)
      UART_CORE: begin
        if (!uart_done) core_clkEn = 1'b0;
        else if (!lat_q.we) begin
          core_rdataEn = 1'b1;
          core_rdata   = uart_ack ? uart_rdata : 32'd0;
        end
      end
      UART_M1: begin
        if (core_req) core_clkEn = 1'b0;
        if (uart_done) begin
          m1_gnt = 1'b1;
          if (!lat_q.we) begin
            m1_rvalid = 1'b1;
            m1_rdata  = uart_ack ? uart_rdata : 32'd0;
          end
        end
      end
      default: ;
    endcase

    if (rd_pend_q) begin
      if (rd_owner_q == MST_CORE) begin
        core_rdataEn = 1'b1;
        core_rdata   = ram_rdata;
      end else begin
        m1_rvalid = 1'b1;
        m1_rdata  = ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: directed sequences with a read-return scoreboard.
module tb_dbus_ctrl;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        rstB;
  logic [31:0] core_addr, core_wdata;
  logic        core_wrEn, core_rdEn;
  logic [3:0]  core_mode;
  logic        core_clkEn, core_rdataEn;
  logic [31:0] core_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_mode;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_mode;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] uart_addr, uart_wdata, uart_rdata;
  logic        uart_we, uart_re, uart_ack;
  logic        bus_err;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  dbus_ctrl dut (
    .clk(clk), .rstB(rstB),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wrEn(core_wrEn),
    .core_rdEn(core_rdEn), .core_mode(core_mode), .core_clkEn(core_clkEn),
    .core_rdata(core_rdata), .core_rdataEn(core_rdataEn),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_mode(m1_mode), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mode(ram_mode),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_we(uart_we),
    .uart_re(uart_re), .uart_rdata(uart_rdata), .uart_ack(uart_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a * 32'd3 + 32'h1000_0001);
  endfunction

  task automatic sb_pop(input logic owner, input logic [31:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_pending", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("rd_owner", 32'(owner), 32'(e.owner));
      chk("rd_data", data, e.data);
      $display("return owner=%0d data=0x%08h", owner, data);
    end
  endtask

  task automatic push(input logic owner, input logic [31:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM slave: one-cycle read latency, garbage when no read was issued
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem_val(ram_addr);
    else        ram_rdata <= 32'hBAD0_BAD0;
  end

  // Read-return monitor
  always @(negedge clk) begin
    if (rstB === 1'b1) begin
      if (core_rdataEn === 1'b1) sb_pop(1'b0, core_rdata);
      if (m1_rvalid === 1'b1)    sb_pop(1'b1, m1_rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    int done_at;
    rstB = 1'b0; core_addr = '0; core_wdata = '0; core_wrEn = 1'b0; core_rdEn = 1'b0;
    core_mode = '0; m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    m1_mode = '0; uart_rdata = '0; uart_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstB = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_strobes", 32'({ram_we, ram_re, uart_we, uart_re, m1_gnt, m1_rvalid, core_rdataEn}), 32'd0);
    chk("rst_clken", 32'(core_clkEn), 32'd1);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    $display("txn reset done");

    // Core RAM load
    tick();
    core_rdEn = 1'b1; core_addr = 32'h100; core_mode = 4'b0010;
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("lw_ram_re", 32'(ram_re), 32'd1);
    chk("lw_ram_addr", ram_addr, 32'h100);
    chk("lw_ram_mode", 32'(ram_mode), 32'd2);
    chk("lw_clken", 32'(core_clkEn), 32'd1);
    tick();
    core_rdEn = 1'b0;
    @(negedge clk);
    chk("lw_rdataEn", 32'(core_rdataEn), 32'd1);
    chk("lw_clken_ret", 32'(core_clkEn), 32'd1);
    $display("txn core lw 0x100");

    // Core UART store, ack on the fourth strobe cycle, M1 waiting for RAM
    tick();
    core_wrEn = 1'b1; core_addr = 32'h8000_0004; core_wdata = 32'h41;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; m1_mode = 4'b0010;
    stall_cnt = 0;
    @(negedge clk);
    chk("sw_issue_uwe", 32'(uart_we), 32'd0);
    chk("sw_issue_gnt", 32'(m1_gnt), 32'd0);
    chk("sw_issue_ramwe", 32'(ram_we), 32'd0);
    if (!core_clkEn) stall_cnt++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) uart_ack = 1'b1;
      @(negedge clk);
      chk("sw_uart_we", 32'(uart_we), 32'd1);
      chk("sw_m1_refused", 32'(m1_gnt), 32'd0);
      if (k == 1) begin
        chk("sw_uart_addr", uart_addr, 32'h8000_0004);
        chk("sw_uart_wdata", uart_wdata, 32'h41);
      end
      if (k == 4) chk("sw_ack_clken", 32'(core_clkEn), 32'd1);
      if (!core_clkEn) stall_cnt++;
    end
    chk("sw_stall_cycles", 32'(stall_cnt), 32'd4);
    tick();
    uart_ack = 1'b0; core_wrEn = 1'b0;
    push(1'b1, mem_val(32'h200));
    @(negedge clk);
    chk("m1_ram_gnt", 32'(m1_gnt), 32'd1);
    chk("m1_ram_addr", ram_addr, 32'h200);
    chk("m1_uart_idle", 32'(uart_we), 32'd0);
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    chk("m1_ram_rvalid", 32'(m1_rvalid), 32'd1);
    $display("txn core sw uart 0x80000004, then m1 lw 0x200");

    // Starvation: both masters hit RAM five cycles running
    for (int k = 0; k < 5; k++) begin
      tick();
      core_rdEn = 1'b1; core_addr = 32'h300 + 32'(k * 4);
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h400;
      if (k < 4) push(1'b0, mem_val(core_addr));
      else       push(1'b1, mem_val(32'h400));
      @(negedge clk);
      if (k < 4) begin
        chk("stv_core_gnt", 32'(m1_gnt), 32'd0);
        chk("stv_core_clken", 32'(core_clkEn), 32'd1);
        chk("stv_core_addr", ram_addr, core_addr);
      end else begin
        chk("stv_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("stv_m1_clken", 32'(core_clkEn), 32'd0);
        chk("stv_m1_addr", ram_addr, 32'h400);
      end
      $display("txn starve cycle %0d gnt=%0d clkEn=%0d", k, m1_gnt, core_clkEn);
    end
    tick();
    m1_req = 1'b0;
    push(1'b0, mem_val(core_addr));
    @(negedge clk);
    chk("stv_retry_clken", 32'(core_clkEn), 32'd1);
    chk("stv_retry_addr", ram_addr, 32'h310);
    tick();
    core_rdEn = 1'b0;
    @(negedge clk);

    // Core UART load that never gets acked
    tick();
    core_rdEn = 1'b1; core_addr = 32'h8000_0010; uart_rdata = 32'h1234_5678;
    push(1'b0, 32'd0);
    @(negedge clk);
    chk("tmo_issue_clken", 32'(core_clkEn), 32'd0);
    done_at = -1;
    for (int i = 0; i < 300 && done_at < 0; i++) begin
      tick();
      @(negedge clk);
      if (i == 0) chk("tmo_uart_re", 32'(uart_re), 32'd1);
      if (core_rdataEn) begin
        done_at = i;
        chk("tmo_clken", 32'(core_clkEn), 32'd1);
        chk("tmo_err_pre", 32'(bus_err), 32'd0);
      end
    end
    chk("tmo_cycle", 32'(done_at), 32'd255);
    tick();
    core_rdEn = 1'b0;
    @(negedge clk);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_uart_re_off", 32'(uart_re), 32'd0);
    $display("txn core lw uart timeout at cycle %0d", done_at);

    // M1 UART load acked, core stalled behind it on RAM
    tick();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0020; uart_rdata = 32'hCAFE_0001;
    push(1'b1, 32'hCAFE_0001);
    @(negedge clk);
    chk("m1u_issue_gnt", 32'(m1_gnt), 32'd0);
    chk("m1u_issue_re", 32'(uart_re), 32'd0);
    tick();
    core_rdEn = 1'b1; core_addr = 32'h500;
    @(negedge clk);
    chk("m1u_uart_re", 32'(uart_re), 32'd1);
    chk("m1u_core_stall", 32'(core_clkEn), 32'd0);
    chk("m1u_no_ram", 32'(ram_re), 32'd0);
    tick();
    uart_ack = 1'b1;
    @(negedge clk);
    chk("m1u_ack_gnt", 32'(m1_gnt), 32'd1);
    chk("m1u_ack_rvalid", 32'(m1_rvalid), 32'd1);
    chk("m1u_ack_stall", 32'(core_clkEn), 32'd0);
    tick();
    uart_ack = 1'b0; m1_req = 1'b0;
    push(1'b0, mem_val(32'h500));
    @(negedge clk);
    chk("m1u_core_go", 32'(core_clkEn), 32'd1);
    chk("m1u_core_ram", 32'(ram_re), 32'd1);
    tick();
    core_rdEn = 1'b0;
    @(negedge clk);
    chk("err_sticky", 32'(bus_err), 32'd1);
    $display("txn m1 lw uart 0x80000020 acked");

    // Reset while M1 holds the UART
    tick();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0030;
    tick();
    @(negedge clk);
    chk("rstm_uart_re", 32'(uart_re), 32'd1);
    tick();
    rstB = 1'b0;
    tick();
    rstB = 1'b1; m1_req = 1'b0; uart_ack = 1'b1;
    @(negedge clk);
    chk("rstm_uart_re_off", 32'(uart_re), 32'd0);
    chk("rstm_no_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rstm_no_gnt", 32'(m1_gnt), 32'd0);
    chk("rstm_bus_err", 32'(bus_err), 32'd0);
    tick();
    uart_ack = 1'b0;
    @(negedge clk);
    $display("txn reset during m1 uart access");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
